snoop_bus_arbiter: RTL and testbench
====================================

// Module: snoop_bus_arbiter
// PURPOSE
//  Shares the single snooping coherence bus between NUM_CPUS cache controllers. Round-robin grants,
//  broadcasts the winner's bus_msg_t to every snooper, collects snoop acks and the shared line, and
//  waits for xbar data delivery before the next grant. One transaction is in flight at a time.
// PARAMETERS
//  NUM_CPUS        2  number of requesting/snooping caches (from types package)
//  TIMEOUT_CYCLES 64  watchdog limit in SNOOP+DATA; 0 disables the watchdog
// PORTS
//  clk             in   1                      system clock
//  rst_n           in   1                      asynchronous active-low reset
//  req_msg_i       in   bus_msg_t [NUM_CPUS]   per-cache request; valid held until gnt_o seen
//  gnt_o           out  [NUM_CPUS]             one-hot grant pulse (BCAST cycle only)
//  bus_msg_o       out  bus_msg_t              broadcast to all snoopers; valid only in BCAST
//  snoop_done_i    in   [NUM_CPUS]             per-cache snoop-complete pulse
//  shared_i        in   [NUM_CPUS]             snooper holds line; qualified by snoop_done_i
//  xfer_done_i     in   1                      xbar delivered line to requester
//  done_o          out  1                      transaction complete pulse (DONE cycle)
//  done_id_o       out  [$clog2(NUM_CPUS):0]   requester index, valid with done_o
//  shared_o        out  1                      any non-source snooper shared; valid with done_o
//  busy_o          out  1                      high whenever state != IDLE
//  err_o           out  1                      sticky watchdog-expired flag
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, all outputs 0 (bus_msg_o all-zero), ack/shared
//   accumulators and watchdog cleared. Reset mid-transaction aborts it; no done_o is produced.
//  Eligible request: req_msg_i[i].valid && bus_tx != Bus_Idle; valid with Bus_Idle is ignored.
//  FSM (arb_state_t):
//   IDLE : any eligible -> pick first eligible at or after rr_ptr (wrap NUM_CPUS-1 -> 0);
//          latch msg, overwrite source with winner index; -> BCAST. Request in cycle t -> BCAST t+1.
//   BCAST: 1 cycle. bus_msg_o.valid=1, gnt_o[winner]=1. Clear ack vec, set ack[winner]=1,
//          shared acc=0, watchdog=0. snoop_done_i ignored this cycle. -> SNOOP.
//   SNOOP: ack |= snoop_done_i; shared |= shared_i & snoop_done_i & ~onehot(winner).
//          Advance when (ack | snoop_done_i) all-ones, same-cycle pulses count.
//          Bus_Upgr -> DONE (no data); else -> DATA.
//   DATA : wait xfer_done_i -> DONE. xfer_done_i outside DATA is ignored.
//   DONE : 1 cycle. done_o=1, done_id_o=winner, shared_o=accumulated value;
//          rr_ptr <= winner+1 with wrap (NUM_CPUS need not be a power of two). -> IDLE.
//  Watchdog: counts each cycle in SNOOP/DATA; on reaching TIMEOUT_CYCLES sets err_o (sticky
//   until reset) and forces -> DONE with shared_o from accumulated value.
//  Requester drops valid the cycle after gnt_o; IDLE never samples the winner's request in DONE.
//  Minimum latency request->done_o: Upgr 3 cycles (BCAST,SNOOP,DONE); Rd/RdX 4 cycles.
//  Duplicate snoop_done_i pulses within one transaction are harmless (OR accumulate).
// STRUCTURE
//  types package: extend bus_tx_t with Bus_RdX, Bus_Upgr; add arb_state_t {ARB_IDLE, ARB_BCAST,
//   ARB_SNOOP, ARB_DATA, ARB_DONE}; add ARB_TIMEOUT default constant.
//  Sub-module rr_arbiter: combinational, inputs req vector + ptr, outputs one-hot gnt + index.
//  Top holds FSM, latched msg, ack/shared accumulators, watchdog, rr_ptr.
// TESTING (NUM_CPUS=2, TIMEOUT_CYCLES=8)
//  1 cpu0 Bus_Rd addr=4'hA at t; snoop_done_i[1]&shared_i[1] at t+2; xfer_done at t+4
//    -> gnt_o=2'b01 and bus_msg_o{valid=1,source=0,addr=A} at t+1; done_o,done_id=0,shared_o=1 at t+5.
//  2 both cpus request Bus_Rd from reset, cpu0 re-requests after its grant
//    -> grant order cpu0, cpu1, cpu0; never cpu0 twice in a row while cpu1 pending.
//  3 cpu1 Bus_Upgr at t, snoop_done_i[0] at t+2 -> done_o at t+3, DATA skipped, xfer_done unused.
//  4 cpu0 Bus_RdX, no snoop_done ever -> err_o=1 and done_o after 8 SNOOP cycles; back to IDLE;
//    err_o stays 1 through next normal transaction.
//  5 rst_n=0 mid-SNOOP -> busy_o, bus_msg_o.valid, gnt_o 0 before next clk edge; next grant from cpu0.
//  6 req valid=1 with bus_tx=Bus_Idle -> no gnt_o, busy_o stays 0 for 10 cycles.

Source files
------------

// File: rtl/snoop_bus_arbiter_pkg.sv
// snoop_bus_arbiter_pkg: shared types and constants for the snooping bus arbiter.
//   bus_tx_t    : coherence bus transaction kinds
//   bus_msg_t   : {valid, bus_tx, source, addr} message carried on the bus
//   arb_state_t : arbiter transaction phases
package snoop_bus_arbiter_pkg;
  localparam int CPU_COUNT = 2;
  localparam int ADDR_W = 8;
  localparam int SRC_W = $clog2(CPU_COUNT) + 1;
  localparam int ARB_TIMEOUT = 64;
  typedef enum logic [1:0] {Bus_Idle, Bus_Rd, Bus_RdX, Bus_Upgr} bus_tx_t;
  typedef struct packed {
    logic              valid;
    bus_tx_t           bus_tx;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] addr;
  } bus_msg_t;
  typedef enum logic [2:0] {ARB_IDLE, ARB_BCAST, ARB_SNOOP, ARB_DATA, ARB_DONE} arb_state_t;
  function automatic int wrap_inc(int v, int n);
    return (v + 1 == n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// snoop_bus_arbiter_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
//   req : request vector      ptr : highest-priority index
//   gnt : one-hot winner      idx : winner index      any : some request present
module snoop_bus_arbiter_rr_arbiter #(
  parameter int N = 2,
  parameter int IW = $clog2(N) + 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++)
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
        gnt[(int'(ptr) + k) % N] = 1'b1;
      end
  end
endmodule

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner of the single snooping coherence bus, one transaction at a time.
//   req_msg_i    : per-cache request (valid + non-idle tx is eligible)
//   gnt_o        : one-hot grant, BCAST cycle only
//   bus_msg_o    : winner's message with source rewritten, BCAST cycle only
//   snoop_done_i : per-cache snoop-complete pulses     shared_i : line held, qualified by snoop_done_i
//   xfer_done_i  : data delivered (only observed while waiting for data)
//   done_o/done_id_o/shared_o : completion pulse, requester index, shared result
//   busy_o       : transaction in flight               err_o : sticky watchdog expiry
module snoop_bus_arbiter
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int NUM_CPUS = CPU_COUNT,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  bus_msg_t                  req_msg_i [NUM_CPUS],
  output logic [NUM_CPUS-1:0]       gnt_o,
  output bus_msg_t                  bus_msg_o,
  input  logic [NUM_CPUS-1:0]       snoop_done_i,
  input  logic [NUM_CPUS-1:0]       shared_i,
  input  logic                      xfer_done_i,
  output logic                      done_o,
  output logic [$clog2(NUM_CPUS):0] done_id_o,
  output logic                      shared_o,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int IW = $clog2(NUM_CPUS) + 1;
  localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  arb_state_t state, state_d;
  logic [NUM_CPUS-1:0] elig, arb_gnt, win_oh, ack;
  logic [IW-1:0] arb_idx, winner, rr_ptr;
  logic arb_any, shared_acc, wd_hit, ack_all;
  logic [WD_W-1:0] wd;
  bus_msg_t msg_q, win_msg;
  snoop_bus_arbiter_rr_arbiter #(.N(NUM_CPUS), .IW(IW)) u_rr (
    .req(elig),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );
  always_comb begin
    elig = '0;
    win_msg = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      elig[i] = req_msg_i[i].valid && req_msg_i[i].bus_tx != Bus_Idle;
      if (IW'(i) == arb_idx) win_msg = req_msg_i[i];
    end
    win_msg.source = SRC_W'(arb_idx);
  end
  // Same-cycle snoop pulses count toward completion; the winner's own ack is preset in BCAST.
  always_comb begin
    ack_all = &(ack | snoop_done_i);
    wd_hit = TIMEOUT_CYCLES != 0 && int'(wd) + 1 == TIMEOUT_CYCLES;
    state_d = state;
    case (state)
      ARB_IDLE:  state_d = arb_any ? ARB_BCAST : ARB_IDLE;
      ARB_BCAST: state_d = ARB_SNOOP;
      ARB_SNOOP: state_d = wd_hit ? ARB_DONE : !ack_all ? ARB_SNOOP :
                           msg_q.bus_tx == Bus_Upgr ? ARB_DONE : ARB_DATA;
      ARB_DATA:  state_d = (wd_hit || xfer_done_i) ? ARB_DONE : ARB_DATA;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
    busy_o = state != ARB_IDLE;
    gnt_o = state == ARB_BCAST ? win_oh : '0;
    bus_msg_o = state == ARB_BCAST ? msg_q : '0;
    done_o = state == ARB_DONE;
    done_id_o = done_o ? winner : '0;
    shared_o = done_o && shared_acc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      rr_ptr <= '0;
      winner <= '0;
      win_oh <= '0;
      msg_q <= '0;
      ack <= '0;
      shared_acc <= 1'b0;
      wd <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_d;
      if (state == ARB_IDLE && arb_any) begin
        winner <= arb_idx;
        win_oh <= arb_gnt;
        msg_q <= win_msg;
      end
      if (state == ARB_BCAST) begin
        ack <= win_oh;
        shared_acc <= 1'b0;
        wd <= '0;
      end
      if (state == ARB_SNOOP) begin
        ack <= ack | snoop_done_i;
        shared_acc <= shared_acc | (|(shared_i & snoop_done_i & ~win_oh));
      end
      if (state == ARB_SNOOP || state == ARB_DATA) begin
        wd <= wd + 1'b1;
        if (wd_hit) err_o <= 1'b1;
      end
      if (state == ARB_DONE) rr_ptr <= IW'(wrap_inc(int'(winner), NUM_CPUS));
    end
  end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: plan-based transaction model with randomized traffic and directed corner cases.
module tb_snoop_bus_arbiter;
  import snoop_bus_arbiter_pkg::*;
  localparam int N = 2;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bus_msg_t req_msg_i [N];
  logic [N-1:0] gnt_o, snoop_done_i, shared_i;
  bus_msg_t bus_msg_o;
  logic xfer_done_i, done_o, shared_o, busy_o, err_o;
  logic [1:0] done_id_o;
  snoop_bus_arbiter #(.NUM_CPUS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_msg_i(req_msg_i), .gnt_o(gnt_o), .bus_msg_o(bus_msg_o),
    .snoop_done_i(snoop_done_i), .shared_i(shared_i), .xfer_done_i(xfer_done_i),
    .done_o(done_o), .done_id_o(done_id_o), .shared_o(shared_o), .busy_o(busy_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  int cyc, n_chk, n_fail;
  logic chk_en = 1'b0;
  logic [N-1:0] e_gnt;
  bus_msg_t e_msg;
  logic e_busy, e_done, e_shared, e_err;
  logic [1:0] e_id;
  int ptr;
  bit err_m;
  bit pending [N];
  bus_msg_t pmsg [N];
  bit rnd_req, noise, sh_all, idle_req0;
  logic [N-1:0] obs_gnt;
  bus_msg_t obs_msg;
  logic obs_shared, obs_err;
  logic [1:0] obs_id;
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    cmp("gnt_o", 32'(gnt_o), 32'(e_gnt));
    cmp("bus_msg_o", 32'(bus_msg_o), 32'(e_msg));
    cmp("busy_o", 32'(busy_o), 32'(e_busy));
    cmp("done_o", 32'(done_o), 32'(e_done));
    cmp("done_id_o", 32'(done_id_o), 32'(e_id));
    cmp("shared_o", 32'(shared_o), 32'(e_shared));
    cmp("err_o", 32'(err_o), 32'(e_err));
  end
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic expect_idle();
    e_gnt = '0; e_msg = '0; e_busy = 0; e_done = 0; e_shared = 0; e_id = '0; e_err = err_m;
  endtask
  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      pending[i] = 0;
      req_msg_i[i] = '0;
    end
    snoop_done_i = '0; shared_i = '0; xfer_done_i = 0;
    ptr = 0; err_m = 0;
    expect_idle();
  endtask
  task automatic do_reset();
    tick();
    reset_model();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask
  task automatic drive_reqs(input int skip);
    for (int i = 0; i < N; i++) begin
      if (i == skip) continue;
      if (!pending[i] && rnd_req && $urandom_range(0, 3) == 0) begin
        pending[i] = 1;
        pmsg[i].valid = 1;
        pmsg[i].bus_tx = bus_tx_t'($urandom_range(1, 3));
        pmsg[i].source = SRC_W'($urandom);
        pmsg[i].addr = ADDR_W'($urandom);
      end
      req_msg_i[i] = pending[i] ? pmsg[i] : '0;
      if (!pending[i] && ((noise && $urandom_range(0, 4) == 0) || (idle_req0 && i == 0))) begin
        req_msg_i[i].valid = 1;
        req_msg_i[i].bus_tx = Bus_Idle;
        req_msg_i[i].addr = ADDR_W'($urandom);
      end
    end
  endtask
  task automatic idle_step(output int w);
    tick();
    drive_reqs(-1);
    snoop_done_i = noise ? N'($urandom) : '0;
    shared_i = N'($urandom);
    xfer_done_i = noise && $urandom_range(0, 1) == 1;
    expect_idle();
    w = -1;
    for (int k = 0; k < N; k++) if (w < 0 && pending[(ptr + k) % N]) w = (ptr + k) % N;
  endtask
  // fd: non-winner snoop delay after BCAST (-1 never, -2 random); fx: DATA wait (-1 random)
  task automatic txn(input int w, input int fd, input int fx, input int abort_at, output int lat);
    int n, s, x, to, dd;
    int p [N];
    bus_msg_t orig, m;
    bit up, shacc, err_new;
    logic [N-1:0] oh;
    n = cyc;
    orig = pmsg[w];
    m = orig;
    m.source = SRC_W'(w);
    up = orig.bus_tx == Bus_Upgr;
    pending[w] = 0;
    oh = N'(1) << w;
    s = n + 2;
    for (int i = 0; i < N; i++) begin
      p[i] = 0;
      if (i == w) continue;
      if (fd == -2) p[i] = ($urandom_range(0, 15) == 0) ? 1 << 30 : n + 2 + int'($urandom_range(0, 4));
      else p[i] = (fd < 0) ? 1 << 30 : n + 2 + fd;
      if (p[i] > s) s = p[i];
    end
    to = n + T + 1;
    x = up ? s : s + 1 + ((fx < 0) ? int'($urandom_range(0, 3)) : fx);
    err_new = x >= to;
    dd = (err_new ? to : x) + 1;
    lat = dd - n;
    shacc = 0;
    for (int c = n + 1; c <= dd; c++) begin
      tick();
      drive_reqs(w);
      req_msg_i[w] = (c == n + 1) ? orig : '0;
      for (int i = 0; i < N; i++)
        snoop_done_i[i] = (i == w) ? (noise && $urandom_range(0, 1) == 1) :
                          (c == p[i]) || (noise && (c > p[i] || c == n + 1) && $urandom_range(0, 3) == 0);
      shared_i = sh_all ? '1 : N'($urandom);
      xfer_done_i = (!up && c == x) || (noise && c <= s && $urandom_range(0, 3) == 0);
      if (c >= n + 2 && c <= s && c <= to) shacc |= |(snoop_done_i & shared_i & ~oh);
      if (c == dd && err_new) err_m = 1;
      e_busy = 1;
      e_gnt = (c == n + 1) ? oh : '0;
      e_msg = (c == n + 1) ? m : '0;
      e_done = c == dd;
      e_id = (c == dd) ? 2'(w) : '0;
      e_shared = (c == dd) && shacc;
      e_err = err_m;
      if (abort_at > 0 && c == n + abort_at) begin
        #1 rst_n = 0;
        #1;
        cmp("rst_busy", 32'(busy_o), 0);
        cmp("rst_valid", 32'(bus_msg_o.valid), 0);
        cmp("rst_gnt", 32'(gnt_o), 0);
        reset_model();
        tick();
        rst_n = 1;
        lat = -1;
        return;
      end
      if (c == n + 1 || c == dd) begin
        @(negedge clk);
        #1;
        if (c == n + 1) begin
          obs_gnt = gnt_o;
          obs_msg = bus_msg_o;
        end else begin
          obs_shared = shared_o;
          obs_err = err_o;
          obs_id = done_id_o;
        end
      end
    end
    ptr = (w + 1) % N;
  endtask
  initial begin
    int w, lat;
    bus_msg_t t1;
    rnd_req = 0; noise = 0; sh_all = 0; idle_req0 = 0;
    cyc = 0; n_chk = 0; n_fail = 0;
    reset_model();
    #2 rst_n = 0;
    tick();
    chk_en = 1;
    tick();
    rst_n = 1;
    // 1: cpu0 Rd addr A, cpu1 snoops shared two cycles later, data two cycles after that
    pending[0] = 1;
    pmsg[0] = '{valid: 1'b1, bus_tx: Bus_Rd, source: 2'd3, addr: 8'h0A};
    sh_all = 1;
    idle_step(w);
    cmp("t1_winner", 32'(w), 0);
    txn(0, 0, 1, 0, lat);
    t1 = '{valid: 1'b1, bus_tx: Bus_Rd, source: 2'd0, addr: 8'h0A};
    cmp("t1_latency", 32'(lat), 5);
    cmp("t1_gnt", 32'(obs_gnt), 1);
    cmp("t1_msg", 32'(obs_msg), 32'(t1));
    cmp("t1_shared", 32'(obs_shared), 1);
    cmp("t1_id", 32'(obs_id), 0);
    sh_all = 0;
    // 2: both request from reset; cpu0 re-requests after its grant
    do_reset();
    pending[0] = 1; pmsg[0] = '{valid: 1'b1, bus_tx: Bus_Rd, source: 2'd0, addr: 8'h11};
    pending[1] = 1; pmsg[1] = '{valid: 1'b1, bus_tx: Bus_Rd, source: 2'd0, addr: 8'h22};
    idle_step(w);
    txn(w, 0, 0, 0, lat);
    cmp("t2_grant1", 32'(obs_gnt), 1);
    pending[0] = 1;
    idle_step(w);
    txn(w, 0, 0, 0, lat);
    cmp("t2_grant2", 32'(obs_gnt), 2);
    idle_step(w);
    txn(w, 0, 0, 0, lat);
    cmp("t2_grant3", 32'(obs_gnt), 1);
    // 3: cpu1 upgrade skips the data phase
    pending[1] = 1; pmsg[1] = '{valid: 1'b1, bus_tx: Bus_Upgr, source: 2'd0, addr: 8'h33};
    idle_step(w);
    txn(w, 0, 0, 0, lat);
    cmp("t3_latency", 32'(lat), 3);
    cmp("t3_gnt", 32'(obs_gnt), 2);
    cmp("t3_id", 32'(obs_id), 1);
    // 4: cpu0 RdX with a silent snooper trips the watchdog; err stays through the next transaction
    pending[0] = 1; pmsg[0] = '{valid: 1'b1, bus_tx: Bus_RdX, source: 2'd0, addr: 8'h44};
    idle_step(w);
    txn(w, -1, 0, 0, lat);
    cmp("t4_latency", 32'(lat), 10);
    cmp("t4_err", 32'(obs_err), 1);
    pending[0] = 1; pmsg[0] = '{valid: 1'b1, bus_tx: Bus_Rd, source: 2'd0, addr: 8'h45};
    idle_step(w);
    txn(w, 0, 0, 0, lat);
    cmp("t4_latency2", 32'(lat), 4);
    cmp("t4_err_sticky", 32'(obs_err), 1);
    // 5: reset in the middle of a snoop phase restarts the round-robin at cpu0
    pending[0] = 1; pmsg[0] = '{valid: 1'b1, bus_tx: Bus_Rd, source: 2'd0, addr: 8'h55};
    idle_step(w);
    txn(w, 3, 0, 2, lat);
    pending[0] = 1; pmsg[0] = '{valid: 1'b1, bus_tx: Bus_Rd, source: 2'd0, addr: 8'h56};
    pending[1] = 1; pmsg[1] = '{valid: 1'b1, bus_tx: Bus_Rd, source: 2'd0, addr: 8'h57};
    idle_step(w);
    txn(w, 0, 0, 0, lat);
    cmp("t5_gnt_after_reset", 32'(obs_gnt), 1);
    idle_step(w);
    txn(w, 0, 0, 0, lat);
    // 6: valid with Bus_Idle is never granted
    idle_req0 = 1;
    for (int k = 0; k < 10; k++) begin
      idle_step(w);
      cmp("t6_busy", 32'(busy_o), 0);
    end
    idle_req0 = 0;
    // randomized traffic
    rnd_req = 1;
    noise = 1;
    for (int k = 0; k < 300; k++) begin
      idle_step(w);
      if (w >= 0) txn(w, -2, -1, 0, lat);
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
